// File: rtl/sim_avalon_src_gen.sv
// Avalon-ST packet source with ready latency 0. Each start pulse latches a
// configuration and begins emitting packets. Packets carry an incrementing,
// decrementing, PRBS-15 or constant payload, and are separated by a
// programmable gap.
//
// Ports:
//   I_clk, I_rst     clock, asynchronous active-high reset
//   I_start, I_stop  start pulse (only acts in IDLE); sticky stop request
//   I_mod            payload mode: 0 inc, 1 dec, 2 PRBS-15, 3 constant
//   I_pkt_len        beats per packet (0 is treated as 1)
//   I_gap            idle cycles between an eop beat and the next sop beat
//   I_pkt_num        number of packets (0 means continuous)
//   I_const          payload for constant mode
//   I_src_rdy        sink ready
//   I_thr            optional: idle cycles inserted after each non-eop beat
//   O_src_*          Avalon-ST sop/eop/valid/data
//   O_busy           high whenever the state is not IDLE
//   O_pkt_cnt        packets completed since start, saturating
//
// Optional feature macro: SIM_AVALON_SRC_THROTTLE_EN (adds the I_thr port).
module sim_avalon_src_gen #(
  parameter int unsigned DW    = 8,
  parameter int unsigned LEN_W = 11,
  parameter int unsigned GAP_W = 8,
  parameter int unsigned CNT_W = 16
) (
  input  logic             I_clk,
  input  logic             I_rst,
  input  logic             I_start,
  input  logic             I_stop,
  input  logic [1:0]       I_mod,
  input  logic [LEN_W-1:0] I_pkt_len,
  input  logic [GAP_W-1:0] I_gap,
  input  logic [CNT_W-1:0] I_pkt_num,
  input  logic [DW-1:0]    I_const,
  input  logic             I_src_rdy,
`ifdef SIM_AVALON_SRC_THROTTLE_EN
  input  logic [3:0]       I_thr,
`endif
  output logic             O_src_sop,
  output logic             O_src_eop,
  output logic             O_src_val,
  output logic [DW-1:0]    O_src_dat,
  output logic             O_busy,
  output logic [CNT_W-1:0] O_pkt_cnt
);

  localparam int unsigned LFSR_W = 15;
  localparam int unsigned THR_W  = 4;
  localparam logic [LFSR_W-1:0] LFSR_SEED = 15'h7FFF;

  typedef enum logic [1:0] {ST_IDLE, ST_SEND, ST_GAP} state_e;
  typedef enum logic [1:0] {
    MOD_INC   = 2'd0,
    MOD_DEC   = 2'd1,
    MOD_PRBS  = 2'd2,
    MOD_CONST = 2'd3
  } mod_e;

  state_e             state_q, state_d;
  mod_e               mod_q, mod_d;
  logic [LEN_W-1:0]   len_q, len_d, len_eff;
  logic [GAP_W-1:0]   gap_q, gap_d, gap_cnt_q, gap_cnt_d;
  logic [CNT_W-1:0]   num_q, num_d, pkt_cnt_q, pkt_cnt_d;
  logic [DW-1:0]      const_q, const_d, cnt_q, cnt_d, cnt_init, dat_q, dat_d;
  logic [LFSR_W-1:0]  lfsr_q, lfsr_d;
  logic [THR_W-1:0]   thr_q, thr_d, thr_cnt_q, thr_cnt_d, thr_in;
  logic [LEN_W-1:0]   beat_q, beat_d;
  logic               stop_q, stop_d;
  logic               sop_q, sop_d, eop_q, eop_d, val_q, val_d, busy_q, busy_d;
  logic               xfer, pkt_last, stop_now;

`ifdef SIM_AVALON_SRC_THROTTLE_EN
  assign thr_in = I_thr;
`else
  assign thr_in = '0;
`endif

  // Payload for a given generator state; PRBS is zero-extended when DW > 15.
  function automatic logic [DW-1:0] pick_dat(mod_e m, logic [DW-1:0] c,
                                             logic [LFSR_W-1:0] l,
                                             logic [DW-1:0] k);
    logic [DW+LFSR_W-1:0] ext;
    ext = {{DW{1'b0}}, l};
    case (m)
      MOD_PRBS:  pick_dat = ext[DW-1:0];
      MOD_CONST: pick_dat = k;
      default:   pick_dat = c;
    endcase
  endfunction

  // Next-state and registered-output computation.
  always_comb begin
    state_d   = state_q;
    mod_d     = mod_q;
    len_d     = len_q;
    gap_d     = gap_q;
    num_d     = num_q;
    const_d   = const_q;
    thr_d     = thr_q;
    thr_cnt_d = thr_cnt_q;
    gap_cnt_d = gap_cnt_q;
    pkt_cnt_d = pkt_cnt_q;
    cnt_d     = cnt_q;
    lfsr_d    = lfsr_q;
    beat_d    = beat_q;
    stop_d    = stop_q;
    sop_d     = sop_q;
    eop_d     = eop_q;
    val_d     = val_q;
    dat_d     = dat_q;
    len_eff   = (I_pkt_len == '0) ? LEN_W'(1) : I_pkt_len;
    cnt_init  = (I_mod == MOD_DEC) ? '1 : '0;
    xfer      = val_q & I_src_rdy;
    // pkt_cnt never saturates before reaching a non-zero num, so it doubles as the packet counter
    pkt_last  = (num_q != '0) && ((pkt_cnt_q + CNT_W'(1)) == num_q);
    stop_now  = stop_q | I_stop;

    if ((state_q != ST_IDLE) && I_stop) stop_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        val_d  = 1'b0;
        sop_d  = 1'b0;
        eop_d  = 1'b0;
        stop_d = 1'b0;
        if (I_start) begin
          mod_d     = mod_e'(I_mod);
          len_d     = len_eff;
          gap_d     = I_gap;
          num_d     = I_pkt_num;
          const_d   = I_const;
          thr_d     = thr_in;
          thr_cnt_d = '0;
          pkt_cnt_d = '0;
          beat_d    = '0;
          cnt_d     = cnt_init;
          lfsr_d    = LFSR_SEED;
          state_d   = ST_SEND;
          val_d     = 1'b1;
          sop_d     = 1'b1;
          eop_d     = (len_eff == LEN_W'(1));
          dat_d     = pick_dat(mod_e'(I_mod), cnt_init, LFSR_SEED, I_const);
        end
      end

      ST_SEND: begin
        if (xfer) begin
          case (mod_q)
            MOD_INC:  cnt_d  = cnt_q + DW'(1);
            MOD_DEC:  cnt_d  = cnt_q - DW'(1);
            MOD_PRBS: lfsr_d = {lfsr_q[LFSR_W-2:0], lfsr_q[14] ^ lfsr_q[13]};
            default:  cnt_d  = cnt_q;
          endcase
          dat_d = pick_dat(mod_q, cnt_d, lfsr_d, const_q);
          if (eop_q) begin
            pkt_cnt_d = (&pkt_cnt_q) ? pkt_cnt_q : pkt_cnt_q + CNT_W'(1);
            beat_d    = '0;
            if (stop_now || pkt_last) begin
              state_d = ST_IDLE;
              val_d   = 1'b0;
              sop_d   = 1'b0;
              eop_d   = 1'b0;
              stop_d  = 1'b0;
            end else if (gap_q != '0) begin
              state_d   = ST_GAP;
              gap_cnt_d = gap_q;
              val_d     = 1'b0;
              sop_d     = 1'b0;
              eop_d     = 1'b0;
            end else begin
              sop_d = 1'b1;
              eop_d = (len_q == LEN_W'(1));
            end
          end else begin
            beat_d = beat_q + LEN_W'(1);
            sop_d  = 1'b0;
            eop_d  = ((beat_q + LEN_W'(2)) == len_q);
            if (thr_q != '0) begin
              val_d     = 1'b0;
              thr_cnt_d = thr_q;
            end
          end
        end else if (!val_q) begin
          // Throttle bubble: beat fields hold, only the bubble counter moves
          thr_cnt_d = thr_cnt_q - THR_W'(1);
          if (thr_cnt_q == THR_W'(1)) val_d = 1'b1;
        end
      end

      ST_GAP: begin
        if (gap_cnt_q == GAP_W'(1)) begin
          if (stop_now) begin
            state_d = ST_IDLE;
            stop_d  = 1'b0;
          end else begin
            state_d = ST_SEND;
            val_d   = 1'b1;
            sop_d   = 1'b1;
            eop_d   = (len_q == LEN_W'(1));
          end
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end

      default: state_d = ST_IDLE;
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  // State and output registers.
  always_ff @(posedge I_clk or posedge I_rst) begin
    if (I_rst) begin
      state_q   <= ST_IDLE;
      mod_q     <= MOD_INC;
      len_q     <= '0;
      gap_q     <= '0;
      num_q     <= '0;
      const_q   <= '0;
      thr_q     <= '0;
      thr_cnt_q <= '0;
      gap_cnt_q <= '0;
      pkt_cnt_q <= '0;
      cnt_q     <= '0;
      lfsr_q    <= '0;
      beat_q    <= '0;
      stop_q    <= 1'b0;
      sop_q     <= 1'b0;
      eop_q     <= 1'b0;
      val_q     <= 1'b0;
      dat_q     <= '0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      mod_q     <= mod_d;
      len_q     <= len_d;
      gap_q     <= gap_d;
      num_q     <= num_d;
      const_q   <= const_d;
      thr_q     <= thr_d;
      thr_cnt_q <= thr_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      pkt_cnt_q <= pkt_cnt_d;
      cnt_q     <= cnt_d;
      lfsr_q    <= lfsr_d;
      beat_q    <= beat_d;
      stop_q    <= stop_d;
      sop_q     <= sop_d;
      eop_q     <= eop_d;
      val_q     <= val_d;
      dat_q     <= dat_d;
      busy_q    <= busy_d;
    end
  end

  assign O_src_sop = sop_q;
  assign O_src_eop = eop_q;
  assign O_src_val = val_q;
  assign O_src_dat = dat_q;
  assign O_busy    = busy_q;
  assign O_pkt_cnt = pkt_cnt_q;

endmodule

// File: doc/sim_avalon_src_gen.md
Name: sim_avalon_src_gen

Overview:
Parametrised Avalon-ST packet source for simulation benches and on-chip loopback tests. It succeeds the fixed 8-bit source and adds configurable data width, packet length, inter-packet gap, packet count and four payload modes. The block drives a downstream Avalon-ST sink with ready latency 0 and honours backpressure through I_src_rdy.

Parameters:
DW, 8, data bus width in bits (1..64)
LEN_W, 11, width of the packet-length field
GAP_W, 8, width of the inter-packet gap field
CNT_W, 16, width of the packet-count field and counter

Ports:
I_clk  input  1  clock; all logic on the rising edge
I_rst  input  1  asynchronous, active-high reset
I_start  input  1  one-cycle pulse; latches config and starts generation (ignored unless IDLE)
I_stop  input  1  one-cycle pulse; finish the current packet, then go IDLE
I_mod  input  2  payload mode: 0 increment, 1 decrement, 2 PRBS-15, 3 constant
I_pkt_len  input  LEN_W  beats per packet; 0 treated as 1
I_gap  input  GAP_W  idle cycles between the eop beat and the next sop beat
I_pkt_num  input  CNT_W  packets to send; 0 means continuous
I_const  input  DW  payload value for mode 3
I_src_rdy  input  1  sink ready
O_src_sop  output  1  start of packet
O_src_eop  output  1  end of packet
O_src_val  output  1  data valid
O_src_dat  output  DW  payload
O_busy  output  1  high whenever the state is not IDLE
O_pkt_cnt  output  CNT_W  packets completed since the last start; saturates at all-ones

Behaviour:
- Reset (async, active-high): state IDLE, and all outputs 0.
- Handshake:
  - A beat transfers when O_src_val & I_src_rdy.
  - While O_src_val=1 and I_src_rdy=0, O_src_sop, O_src_eop and O_src_dat hold stable.
  - Payload and beat counters advance only on a transfer.
- FSM is IDLE -> SEND <-> GAP -> IDLE.
  - IDLE: O_src_val=0. On I_start, latch I_mod, I_pkt_len, I_gap, I_pkt_num and I_const. Initialise the payload generator, clear O_pkt_cnt, then go to SEND. First valid beat is the cycle after I_start (latency 1).
  - SEND: O_src_val=1.
    - O_src_sop=1 on beat 0; O_src_eop=1 on beat len-1.
    - len=1 gives sop and eop on the same beat.
    - On eop transfer, O_pkt_cnt increments.
    - Next state after the eop transfer: IDLE if the stop flag is set or the final packet is done; GAP if gap>0; otherwise SEND with no bubble.
  - GAP: O_src_val=0 for exactly gap cycles, counted from the cycle after the eop transfer, then SEND.
    - If the stop flag is set during GAP, go to IDLE at the end of the gap.
- I_stop:
  - Sets a sticky stop flag when not IDLE; the flag clears on entering IDLE.
  - Never truncates a packet.
  - I_stop during IDLE is ignored.
  - I_start and I_stop in the same cycle while IDLE: start wins, and the stop is ignored.
- Payload generator:
  - Mode 0: counter starts at 0 and adds 1 per transfer, wrapping modulo 2^DW. It continues across packets.
  - Mode 1: starts at all-ones and subtracts 1 per transfer, wrapping.
  - Mode 2: PRBS-15, polynomial x^15+x^14+1, seed 15'h7FFF, one shift per transfer. O_src_dat is the low DW bits of the LFSR, zero-extended when DW>15.
  - Mode 3: O_src_dat = I_const latched at start.
- Config inputs are sampled only at start; changes mid-run have no effect.
- O_pkt_cnt saturates at all-ones in continuous mode and never wraps.
- Reset mid-packet aborts immediately. No eop is issued for the aborted packet.

Optional Feature:
SIM_AVALON_SRC_THROTTLE_EN
- Defined: adds input I_thr[3:0], latched at start.
  - After every transfer inside a packet (not the eop beat), O_src_val drops for I_thr cycles before the next beat.
  - Idle beats leave O_src_sop, O_src_eop and O_src_dat unchanged and do not advance counters.
  - I_thr=0 behaves identically to the undefined build.
- Undefined: no I_thr port. Within a packet, O_src_val is held continuously high, and only I_src_rdy stalls transfers.

Test Plan:
- Reset sequence: I_rst high for 3 cycles mid-packet -> all outputs 0 immediately; after release O_busy=0 and no val until I_start.
- Increment, back-to-back: DW=8, mod=0, len=4, gap=0, num=2, rdy=1 -> 8 consecutive val cycles with dat 0..7, sop on beats 0 and 4, eop on beats 3 and 7; O_pkt_cnt=2; O_busy falls the cycle after the last eop.
- Single-beat packets with gap: mod=3, const=8'hA5, len=1, gap=3, num=3 -> three beats with sop=eop=1 and dat=A5, each separated by exactly 3 idle cycles.
- Backpressure: mod=0, len=5, rdy toggling 1,0,0,1,... -> O_src_dat held stable while rdy=0; transferred sequence exactly 0..4 with no duplicates or gaps.
- PRBS, continuous, stop: mod=2, len=8, num=0, I_stop pulse on beat 10 -> first dat = 8'hFF; stream matches the reference LFSR model; generation ends after the eop of packet 2 (beat 15); O_pkt_cnt=2.
- Len 0 and wrap: mod=1, len=0, num=300, gap=0 -> 300 single-beat packets; dat runs FF down to 00 then wraps to FF; O_pkt_cnt=300.
